// File: rtl/code_mem_pkg.sv
// Shared types and constants for the code-memory sequencer: default widths,
// FSM state encoding and the arbiter grant encoding.
package code_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    RD_DONE   = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_LOAD  = 1'b1;

  function automatic logic is_write_state(input state_t s);
    return (s == WR_SETUP) || (s == WR_STROBE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/code_mem_ctrl_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; when both request, the
// one that did not win last time is granted.
module rr_arb2
  import code_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  always_comb begin
    valid = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1] ? GNT_LOAD : GNT_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_grant <= GNT_FETCH;
    else if (take && valid)    last_grant <= grant;
  end

endmodule

// File: rtl/code_mem_ctrl.sv
// Sequencer/arbiter sharing the single code-memory port between instruction
// fetch and the program loader, with registered glitch-free memory controls.
module code_mem_ctrl
  import code_mem_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WR_STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_instr,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (WR_STROBE_CYC > 1) ? $clog2(WR_STROBE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_STROBE_CYC - 1);

  generate
    if (WR_STROBE_CYC < 1) begin : g_bad_strobe
      $error("code_mem_ctrl: WR_STROBE_CYC must be at least 1");
    end
  endgenerate

  state_t           state, next_state;
  logic [CNT_W-1:0] strobe_cnt;
  logic             arb_grant, arb_valid, take;
  logic             mem_en_d, mem_rw_d, busy_d, fetch_ack_d, ld_ack_d;

  assign take = (state == IDLE) && arb_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({ld_req, fetch_req}),
    .take  (take),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (arb_valid) next_state = (arb_grant == GNT_LOAD) ? WR_SETUP : RD;
      RD:        next_state = RD_DONE;
      RD_DONE:   next_state = IDLE;
      WR_SETUP:  next_state = WR_STROBE;
      WR_STROBE: if (strobe_cnt == '0) next_state = WR_HOLD;
      WR_HOLD:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so every strobe,
  // select and ack comes straight off a flop.
  always_comb begin
    mem_en_d    = (next_state == WR_STROBE);
    mem_rw_d    = is_write_state(next_state);
    busy_d      = (next_state != IDLE);
    fetch_ack_d = (next_state == RD_DONE);
    ld_ack_d    = (next_state == WR_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      busy      <= 1'b0;
      fetch_ack <= 1'b0;
      ld_ack    <= 1'b0;
    end else begin
      mem_en    <= mem_en_d;
      mem_rw    <= mem_rw_d;
      busy      <= busy_d;
      fetch_ack <= fetch_ack_d;
      ld_ack    <= ld_ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       strobe_cnt <= '0;
    else if (state == WR_SETUP)                       strobe_cnt <= CNT_LOAD;
    else if (state == WR_STROBE && strobe_cnt != '0)  strobe_cnt <= strobe_cnt - 1'b1;
  end

  // Address/data captured once at grant; requester changes afterwards are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fetch_instr <= '0;
    end else begin
      if (take) begin
        if (arb_grant == GNT_LOAD) begin
          mem_addr  <= ld_addr;
          mem_wdata <= ld_data;
        end else begin
          mem_addr  <= fetch_addr;
        end
      end
      if (state == RD) fetch_instr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_code_mem_ctrl.sv
// Bench for code_mem_ctrl: two instances (strobe 1 and 3 cycles) each driving
// a behavioural 256x16 memory; acks are checked against a scoreboard queue.
module tb_code_mem_ctrl;

  typedef struct {
    bit          is_ld;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  fetch_req, ld_req, fetch_ack, ld_ack, busy, m_en, m_rw;
  logic [7:0]  fetch_addr [2];
  logic [7:0]  ld_addr    [2];
  logic [7:0]  m_addr     [2];
  logic [15:0] ld_data    [2];
  logic [15:0] fetch_instr[2];
  logic [15:0] m_wdata    [2];
  logic [15:0] m_rdata    [2];
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   rises [2];
  int   en_len[2];
  logic prev_en[2];
  logic prev_rw[2];
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  code_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WR_STROBE_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_ack(fetch_ack[0]),
    .fetch_instr(fetch_instr[0]), .ld_req(ld_req[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0]), .ld_ack(ld_ack[0]), .busy(busy[0]), .mem_en(m_en[0]),
    .mem_rw(m_rw[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0])
  );

  code_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WR_STROBE_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_ack(fetch_ack[1]),
    .fetch_instr(fetch_instr[1]), .ld_req(ld_req[1]), .ld_addr(ld_addr[1]),
    .ld_data(ld_data[1]), .ld_ack(ld_ack[1]), .busy(busy[1]), .mem_en(m_en[1]),
    .mem_rw(m_rw[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1])
  );

  // Behavioural memories: write on rising mem_en, asynchronous read.
  always @(posedge m_en[0]) if (m_rw[0]) mem0[m_addr[0]] <= m_wdata[0];
  always @(posedge m_en[1]) if (m_rw[1]) mem1[m_addr[1]] <= m_wdata[1];
  assign m_rdata[0] = mem0[m_addr[0]];
  assign m_rdata[1] = mem1[m_addr[1]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input bit is_ld, input logic [7:0] a,
                          input logic [15:0] v, input int c);
    exp_t e;
    e.is_ld = is_ld; e.addr = a; e.data = v; e.cyc = c;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit   have;
    int   exp_len;
    logic [15:0] mv;
    exp_len = (d == 0) ? 1 : 3;
    if (!rst_n) begin
      prev_en[d] = m_en[d]; prev_rw[d] = m_rw[d]; en_len[d] = 0;
      return;
    end
    if (fetch_ack[d] || ld_ack[d]) begin
      chk($sformatf("ack_exclusive%0d", d), {31'b0, fetch_ack[d] & ld_ack[d]}, 0);
      have = 0;
      if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1; end
      if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1; end
      n_checks++;
      if (!have) begin
        n_fails++;
        $display("FAIL unexpected_ack%0d: got ack with empty scoreboard (cycle %0d)", d, cyc);
      end else begin
        chk($sformatf("ack_kind%0d", d), {31'b0, ld_ack[d]}, {31'b0, e.is_ld});
        if (e.cyc >= 0) chk($sformatf("ack_cycle%0d", d), cyc, e.cyc);
        if (e.is_ld) begin
          mv = (d == 0) ? mem0[e.addr] : mem1[e.addr];
          chk($sformatf("ld_mem%0d", d), {16'b0, mv}, {16'b0, e.data});
          chk($sformatf("ld_addr%0d", d), {24'b0, m_addr[d]}, {24'b0, e.addr});
          chk($sformatf("ld_wdata%0d", d), {16'b0, m_wdata[d]}, {16'b0, e.data});
        end else begin
          chk($sformatf("fetch_instr%0d", d), {16'b0, fetch_instr[d]}, {16'b0, e.data});
        end
      end
    end
    if (m_en[d] && !prev_en[d]) begin
      rises[d]++;
      chk($sformatf("rw_setup%0d", d), {31'b0, prev_rw[d]}, 1);
    end
    if (m_en[d]) en_len[d]++;
    if (!m_en[d] && prev_en[d]) begin
      chk($sformatf("rw_hold%0d", d), {31'b0, m_rw[d]}, 1);
      chk($sformatf("strobe_len%0d", d), en_len[d], exp_len);
      en_len[d] = 0;
    end
    if (m_rw[d] != prev_rw[d])
      chk($sformatf("rw_change_en_low%0d", d), {30'b0, m_en[d], prev_en[d]}, 0);
    prev_en[d] = m_en[d];
    prev_rw[d] = m_rw[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // Issues one transaction from an idle DUT and waits (bounded) for its ack.
  task automatic do_xact(input int d, input bit is_ld, input logic [7:0] a,
                         input logic [15:0] v, input int lat);
    bit got;
    @(negedge clk);
    if (is_ld) begin ld_req[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v; end
    else       begin fetch_req[d] = 1'b1; fetch_addr[d] = a; end
    push_exp(d, is_ld, a, v, cyc + lat);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_ld ? ld_ack[d] : fetch_ack[d]) got = 1;
    end
    ld_req[d] = 1'b0;
    fetch_req[d] = 1'b0;
    n_checks++;
    if (!got) begin
      n_fails++;
      $display("FAIL ack_timeout%0d: no ack within 40 cycles, expected one", d);
    end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk($sformatf("rst_fetch_ack%0d", d), {31'b0, fetch_ack[d]}, 0);
    chk($sformatf("rst_ld_ack%0d", d), {31'b0, ld_ack[d]}, 0);
    chk($sformatf("rst_busy%0d", d), {31'b0, busy[d]}, 0);
    chk($sformatf("rst_mem_en%0d", d), {31'b0, m_en[d]}, 0);
    chk($sformatf("rst_mem_rw%0d", d), {31'b0, m_rw[d]}, 0);
    chk($sformatf("rst_mem_addr%0d", d), {24'b0, m_addr[d]}, 0);
    chk($sformatf("rst_mem_wdata%0d", d), {16'b0, m_wdata[d]}, 0);
    chk($sformatf("rst_fetch_instr%0d", d), {16'b0, fetch_instr[d]}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, acks;
    bit  got;
    rst_n = 1'b0;
    fetch_req = '0; ld_req = '0;
    for (int d = 0; d < 2; d++) begin
      fetch_addr[d] = '0; ld_addr[d] = '0; ld_data[d] = '0;
      rises[d] = 0; en_len[d] = 0; prev_en[d] = 0; prev_rw[d] = 0;
    end
    mem0[8'h10] = 16'hA5C3;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst_n = 1'b1;

    // Fetch only: ack two cycles after grant, no write strobe.
    r0 = rises[0];
    do_xact(0, 1'b0, 8'h10, 16'hA5C3, 2);
    chk("fetch_no_strobe", rises[0], r0);

    // Write to the top address, then read it back.
    r0 = rises[0];
    do_xact(0, 1'b1, 8'hFF, 16'h1234, 3);
    chk("write_one_strobe", rises[0], r0 + 1);
    do_xact(0, 1'b0, 8'hFF, 16'h1234, 2);

    // Contention: both held; grants must alternate load, fetch, load, fetch.
    @(negedge clk);
    fetch_req[0] = 1'b1; fetch_addr[0] = 8'h20;
    ld_req[0] = 1'b1; ld_addr[0] = 8'h20; ld_data[0] = 16'hBEEF;
    push_exp(0, 1'b1, 8'h20, 16'hBEEF, -1);
    push_exp(0, 1'b0, 8'h20, 16'hBEEF, -1);
    push_exp(0, 1'b1, 8'h20, 16'hCAFE, -1);
    push_exp(0, 1'b0, 8'h20, 16'hCAFE, -1);
    acks = 0;
    for (int i = 0; i < 80 && acks < 4; i++) begin
      @(negedge clk);
      if (ld_ack[0] && acks == 0) ld_data[0] = 16'hCAFE;
      if (ld_ack[0] || fetch_ack[0]) acks++;
    end
    fetch_req[0] = 1'b0; ld_req[0] = 1'b0;
    chk("contention_acks", acks, 4);

    // Three-cycle strobe instance.
    do_xact(1, 1'b1, 8'h05, 16'h5A5A, 5);
    do_xact(1, 1'b0, 8'h05, 16'h5A5A, 2);

    // Reset in the middle of a read: no ack, everything cleared at once.
    @(negedge clk);
    fetch_req[0] = 1'b1; fetch_addr[0] = 8'h10;
    @(negedge clk);
    chk("mid_read_busy", {31'b0, busy[0]}, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs(0);
    fetch_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while the write strobe is high.
    @(negedge clk);
    ld_req[1] = 1'b1; ld_addr[1] = 8'h07; ld_data[1] = 16'h7777;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (m_en[1]) got = 1;
    end
    chk("strobe_seen_before_reset", {31'b0, got}, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs(1);
    ld_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", {31'b0, busy[1]}, 0);
    do_xact(1, 1'b1, 8'h07, 16'h7777, 5);
    do_xact(1, 1'b0, 8'h07, 16'h7777, 2);

    repeat (4) @(negedge clk);
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
